fifo_uart_tx: RTL and testbench

- Downstream consumer of the synchronous FIFO (`fifo`).
- Pops one byte at a time through the FIFO read port (`r_en`/`rdata`/`rempty`) and shifts it out as an asynchronous serial frame on `tx`: start bit, data LSB first, optional parity, stop bit.
- Sits between the FIFO and the chip's serial output pin.
- Drains the FIFO autonomously whenever it is non-empty.

---
 rtl/fifo_uart_tx_if.sv | 15 +
 rtl/fifo_uart_tx.sv | 140 ++++++++++++++
 tb/tb_fifo_uart_tx.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-port bundle between a synchronous FIFO and its consumer.
//   rempty : FIFO empty flag (FIFO -> consumer)
//   rdata  : read data, valid the cycle after an accepted pop (FIFO -> consumer)
//   r_en   : pop request, one cycle wide (consumer -> FIFO)
// master = consumer side (issues pops), slave = FIFO side.
interface fifo_uart_tx_if #(
  parameter int DATASIZE = 8
);
  logic                rempty;
  logic [DATASIZE-1:0] rdata;
  logic                r_en;

  modport master (input rempty, input rdata, output r_en);
  modport slave  (output rempty, output rdata, input r_en);
endinterface

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that drains a synchronous FIFO byte by byte.
// Each popped word goes out on tx as: start(0), data LSB first,
// optional parity, stop(1); every bit lasts CLKS_PER_BIT clocks.
//   clk         : system clock, posedge
//   rst         : synchronous reset, active low
//   rd          : FIFO read port (r_en out, rdata/rempty in)
//   tx          : serial line, idle high, registered
//   busy        : high while a frame is fetched or sent
//   frames_sent : completed frame count, wraps at 16 bits
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | line idle, pop as soon as the FIFO is non-empty
// S_FETCH  | one cycle, popped word arrives on rdata
// S_START  | start bit (tx=0)
// S_DATA   | DATASIZE data bits, LSB first
// S_PARITY | parity bit (only when PARITY != 0)
// S_STOP   | stop bit (tx=1), counts the frame on its last cycle
module fifo_uart_tx #(
  parameter int DATASIZE     = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0
) (
  input  logic           clk,
  input  logic           rst,
  fifo_uart_tx_if.master rd,
  output logic           tx,
  output logic           busy,
  output logic [15:0]    frames_sent
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATASIZE) + 1;
  // Index of the bit that becomes the LSB after the next shift.
  localparam int NXT    = (DATASIZE > 1) ? 1 : 0;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATASIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_START, S_DATA, S_PARITY, S_STOP
  } state_t;

  state_t              state;
  logic [BAUD_W-1:0]   baud;
  logic [BIT_W-1:0]    bit_cnt;
  logic [DATASIZE-1:0] shreg;
  logic                par_bit;
  logic                baud_end;

  assign baud_end = (baud == BAUD_LAST);

  // Pop is combinational so the FIFO sees it in the same cycle the idle
  // state observes a non-empty flag; gating with rst keeps reset quiet.
  assign rd.r_en = rst & (state == S_IDLE) & ~rd.rempty;
  assign busy    = (state != S_IDLE);

  // tx is loaded on the edge that enters a state, so it already carries
  // that state's bit value during the state's first cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      tx          <= 1'b1;
      baud        <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      par_bit     <= 1'b0;
      frames_sent <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          tx   <= 1'b1;
          baud <= '0;
          if (!rd.rempty) state <= S_FETCH;
        end
        S_FETCH: begin
          shreg   <= rd.rdata;
          par_bit <= (PARITY == 2) ? ~^rd.rdata : ^rd.rdata;
          baud    <= '0;
          tx      <= 1'b0;
          state   <= S_START;
        end
        S_START: begin
          if (baud_end) begin
            baud    <= '0;
            bit_cnt <= '0;
            tx      <= shreg[0];
            state   <= S_DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_end) begin
            baud  <= '0;
            shreg <= shreg >> 1;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[NXT];
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        S_STOP: begin
          if (baud_end) begin
            baud        <= '0;
            tx          <= 1'b1;
            frames_sent <= frames_sent + 16'd1;
            state       <= S_IDLE;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          tx    <= 1'b1;
          baud  <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (no parity, even, odd) at
// CLKS_PER_BIT=4, each fed by a queue-based FIFO model. A frame-level
// reference expands every popped byte into its expected tx waveform and
// is compared against tx/r_en/busy/frames_sent every cycle.
module tb_fifo_uart_tx;
  localparam int C = 4;

  typedef struct packed {
    logic val;
    logic last;
  } ex_t;

  typedef struct {
    int         k;
    logic [7:0] data;
    logic       par;
    int         len;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_v;
  logic       empty_v [3];
  logic [7:0] rdata_v [3];
  logic       tx_w    [3];
  logic       busy_w  [3];
  logic       ren_w   [3];
  logic [15:0] fs_w   [3];

  always #5 clk = ~clk;

  fifo_uart_tx_if #(.DATASIZE(8)) bus0 ();
  fifo_uart_tx_if #(.DATASIZE(8)) bus1 ();
  fifo_uart_tx_if #(.DATASIZE(8)) bus2 ();

  assign bus0.rempty = empty_v[0];
  assign bus1.rempty = empty_v[1];
  assign bus2.rempty = empty_v[2];
  assign bus0.rdata  = rdata_v[0];
  assign bus1.rdata  = rdata_v[1];
  assign bus2.rdata  = rdata_v[2];
  assign ren_w[0]    = bus0.r_en;
  assign ren_w[1]    = bus1.r_en;
  assign ren_w[2]    = bus2.r_en;

  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(C), .PARITY(0)) dut0 (
    .clk(clk), .rst(rst_v), .rd(bus0), .tx(tx_w[0]), .busy(busy_w[0]), .frames_sent(fs_w[0]));
  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(C), .PARITY(1)) dut1 (
    .clk(clk), .rst(rst_v), .rd(bus1), .tx(tx_w[1]), .busy(busy_w[1]), .frames_sent(fs_w[1]));
  fifo_uart_tx #(.DATASIZE(8), .CLKS_PER_BIT(C), .PARITY(2)) dut2 (
    .clk(clk), .rst(rst_v), .rd(bus2), .tx(tx_w[2]), .busy(busy_w[2]), .frames_sent(fs_w[2]));

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         nonidle = 0;
  int         pm [3] = '{0, 1, 2};
  logic [7:0] fq [3][$];
  ex_t        exq [3][$];
  logic [15:0] exp_fs [3];
  logic       tx_log [3][$];
  logic       busy_log [3][$];
  logic       ren_log [3][$];
  int         ren_cyc [$];
  logic [7:0] dec_q [$];
  logic       dec_act = 1'b0;
  int         dec_n = 0;
  logic [7:0] dec_b = 8'h00;

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d actual=%h expected=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask

  // Expand one popped byte into its expected tx sequence, starting with the
  // fetch cycle (line still high).
  task automatic build(input int k, input logic [7:0] b);
    ex_t e;
    logic p;
    e = '{val: 1'b1, last: 1'b0};
    exq[k].push_back(e);
    for (int i = 0; i < C; i++) exq[k].push_back('{val: 1'b0, last: 1'b0});
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < C; j++) exq[k].push_back('{val: b[i], last: 1'b0});
    if (pm[k] != 0) begin
      p = (pm[k] == 1) ? ^b : ~^b;
      for (int j = 0; j < C; j++) exq[k].push_back('{val: p, last: 1'b0});
    end
    for (int j = 0; j < C; j++) exq[k].push_back('{val: 1'b1, last: (j == C - 1)});
  endtask

  task automatic push(input int k, input logic [7:0] b);
    fq[k].push_back(b);
    empty_v[k] = 1'b0;
  endtask

  task automatic clear_logs();
    for (int k = 0; k < 3; k++) begin
      tx_log[k].delete();
      busy_log[k].delete();
      ren_log[k].delete();
    end
  endtask

  task automatic step();
    logic pop [3];
    logic rs;
    ex_t  e;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("tx", k, {15'd0, tx_w[k]}, {15'd0, (exq[k].size() != 0) ? exq[k][0].val : 1'b1});
      chk("r_en", k, {15'd0, ren_w[k]},
          {15'd0, rst_v && (exq[k].size() == 0) && (fq[k].size() != 0)});
      chk("busy", k, {15'd0, busy_w[k]}, {15'd0, exq[k].size() != 0});
      chk("frames", k, fs_w[k], exp_fs[k]);
      pop[k] = ren_w[k] && !empty_v[k];
      tx_log[k].push_back(tx_w[k]);
      busy_log[k].push_back(busy_w[k]);
      ren_log[k].push_back(ren_w[k]);
      if (exq[k].size() != 0) begin
        e = exq[k].pop_front();
        if (e.last) exp_fs[k] = exp_fs[k] + 16'd1;
      end
    end
    if (tx_w[0] == 1'b0 || busy_w[0] || ren_w[0]) nonidle++;
    if (ren_w[0]) ren_cyc.push_back(cyc);
    // Serial monitor on dut0: samples each bit mid-period after a falling edge.
    if (dec_act) begin
      dec_n++;
      if (dec_n % C == C / 2) begin
        if (dec_n / C >= 1 && dec_n / C <= 8) dec_b[dec_n / C - 1] = tx_w[0];
        if (dec_n / C == 9) begin
          chk("mon_stop", 0, {15'd0, tx_w[0]}, 16'd1);
          dec_q.push_back(dec_b);
          dec_act = 1'b0;
        end
      end
    end else if (tx_w[0] == 1'b0) begin
      dec_act = 1'b1;
      dec_n   = 0;
    end
    cyc++;
    rs = rst_v;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      if (!rs) begin
        exq[k].delete();
        exp_fs[k] = 16'd0;
      end
      if (pop[k]) begin
        rdata_v[k] = fq[k].pop_front();
        empty_v[k] = (fq[k].size() == 0);
        if (rs) build(k, rdata_v[k]);
      end
    end
    if (!rs) dec_act = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    vec_t tbl [5];
    logic a5_bits [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int   r, s, cnt, n0, guard, seg, hp;
    logic e;
    logic [7:0] d;

    tbl[0] = '{k: 1, data: 8'h07, par: 1'b1, len: 44};
    tbl[1] = '{k: 2, data: 8'h07, par: 1'b0, len: 44};
    tbl[2] = '{k: 1, data: 8'h80, par: 1'b1, len: 44};
    tbl[3] = '{k: 2, data: 8'h00, par: 1'b1, len: 44};
    tbl[4] = '{k: 0, data: 8'h3F, par: 1'b0, len: 40};

    rst_v = 1'b0;
    for (int k = 0; k < 3; k++) begin
      empty_v[k] = 1'b1;
      rdata_v[k] = 8'h00;
      exp_fs[k]  = 16'd0;
    end
    steps(3);
    rst_v = 1'b1;

    // Empty FIFO: line stays idle.
    nonidle = 0;
    steps(20);
    chk("idle_activity", 0, nonidle[15:0], 16'd0);

    // 0xA5 without parity: exact waveform.
    clear_logs();
    dec_q.delete();
    push(0, 8'hA5);
    steps(50);
    r = -1;
    for (int i = 0; i < ren_log[0].size(); i++)
      if (r < 0 && ren_log[0][i]) r = i;
    chk("a5_ren_seen", 0, {15'd0, r >= 0}, 16'd1);
    if (r < 0) r = 0;
    s = -1;
    for (int i = 0; i < tx_log[0].size(); i++)
      if (s < 0 && !tx_log[0][i]) s = i;
    chk("a5_start_lat", 0, 16'(s - r), 16'd2);
    s = r + 2;
    for (int j = 0; j < 40; j++) begin
      seg = j / C;
      e = (seg == 0) ? 1'b0 : (seg <= 8) ? a5_bits[seg - 1] : 1'b1;
      if (s + j < tx_log[0].size()) chk("a5_wave", 0, {15'd0, tx_log[0][s + j]}, {15'd0, e});
    end
    cnt = 0;
    for (int i = 0; i < busy_log[0].size(); i++) cnt += int'(busy_log[0][i]);
    chk("a5_len", 0, 16'(cnt - 1), 16'd40);
    chk("a5_frames", 0, fs_w[0], 16'd1);
    chk("a5_dec_n", 0, 16'(dec_q.size()), 16'd1);
    if (dec_q.size() > 0) chk("a5_dec", 0, {8'd0, dec_q[0]}, 16'h00A5);

    // Table of single frames: parity bit, stop bit, data and frame length.
    for (int v = 0; v < 5; v++) begin
      clear_logs();
      push(tbl[v].k, tbl[v].data);
      steps(60);
      s = -1;
      for (int i = 0; i < tx_log[tbl[v].k].size(); i++)
        if (s < 0 && !tx_log[tbl[v].k][i]) s = i;
      if (s < 0) s = 0;
      hp = (pm[tbl[v].k] != 0) ? 1 : 0;
      d = 8'h00;
      for (int i = 0; i < 8; i++) d[i] = tx_log[tbl[v].k][s + C * (1 + i) + C / 2];
      chk("vec_data", tbl[v].k, {8'd0, d}, {8'd0, tbl[v].data});
      if (hp == 1)
        chk("vec_parity", tbl[v].k, {15'd0, tx_log[tbl[v].k][s + C * 9 + C / 2]}, {15'd0, tbl[v].par});
      chk("vec_stop", tbl[v].k, {15'd0, tx_log[tbl[v].k][s + C * (9 + hp) + C / 2]}, 16'd1);
      cnt = 0;
      for (int i = 0; i < busy_log[tbl[v].k].size(); i++) cnt += int'(busy_log[tbl[v].k][i]);
      chk("vec_len", tbl[v].k, 16'(cnt - 1), 16'(tbl[v].len));
    end

    // Burst of 16 preloaded bytes.
    rst_v = 1'b0;
    steps(2);
    rst_v = 1'b1;
    ren_cyc.delete();
    dec_q.delete();
    for (int i = 0; i < 16; i++) push(0, 8'(i));
    steps(16 * 42 + 20);
    chk("burst_pops", 0, 16'(ren_cyc.size()), 16'd16);
    for (int i = 1; i < ren_cyc.size() && i < 16; i++)
      chk("burst_gap", 0, 16'(ren_cyc[i] - ren_cyc[i - 1]), 16'd42);
    chk("burst_frames", 0, fs_w[0], 16'd16);
    chk("burst_dec_n", 0, 16'(dec_q.size()), 16'd16);
    for (int i = 0; i < dec_q.size() && i < 16; i++)
      chk("burst_dec", 0, {8'd0, dec_q[i]}, 16'(i));

    // Reset in the middle of 0x3C's data bits, 0x3D queued behind it.
    dec_q.delete();
    n0 = ren_cyc.size();
    push(0, 8'h3C);
    push(0, 8'h3D);
    guard = 0;
    while (ren_cyc.size() == n0 && guard < 20) begin
      step();
      guard++;
    end
    chk("rst_ren_seen", 0, {15'd0, ren_cyc.size() > n0}, 16'd1);
    steps(10);
    rst_v = 1'b0;
    step();
    chk("rst_tx_high", 0, {15'd0, tx_w[0]}, 16'd1);
    chk("rst_frames", 0, fs_w[0], 16'd0);
    steps(2);
    rst_v = 1'b1;
    steps(60);
    chk("rst_pops", 0, 16'(ren_cyc.size() - n0), 16'd2);
    chk("rst_dec_n", 0, 16'(dec_q.size()), 16'd1);
    if (dec_q.size() > 0) chk("rst_dec", 0, {8'd0, dec_q[0]}, 16'h003D);
    chk("rst_frames_after", 0, fs_w[0], 16'd1);

    // Counter wrap: preload 0xFFFF while idle, then send one frame.
    dec_q.delete();
    force dut0.frames_sent = 16'hFFFF;
    exp_fs[0] = 16'hFFFF;
    step();
    release dut0.frames_sent;
    step();
    chk("wrap_preload", 0, fs_w[0], 16'hFFFF);
    push(0, 8'h55);
    steps(50);
    chk("wrap_frames", 0, fs_w[0], 16'h0000);
    chk("wrap_dec_n", 0, 16'(dec_q.size()), 16'd1);
    if (dec_q.size() > 0) chk("wrap_dec", 0, {8'd0, dec_q[0]}, 16'h0055);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
